reg_array_bank: RTL and testbench
=================================

// Module: reg_array_bank
// PURPOSE
//  Parametrised DEPTH x WIDTH register bank; successor to the fixed 16x32 parallel-load array.
//  Adds per-entry addressed write, serial shift-in, registered random read and a valid/ready load handshake.
//  Adds a multi-cycle clear sweep FSM and fill tracking.
//  Sits between datapath producers (matrix/vector units) and consumers that need a full-bank parallel view.
// PARAMETERS
//  WIDTH  32  bits per entry (>=1)
//  DEPTH  16  number of entries (>=2, need not be a power of 2)
//  AW     $clog2(DEPTH)  address width; localparam, not overridable
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              asynchronous, active-high reset
//  mode        in   2              00 hold, 01 parallel load, 10 addressed write, 11 shift-in
//  load_valid  in   1              producer presents an operation selected by mode
//  load_ready  out  1              bank can accept; = (state==IDLE) && !clear
//  data_in     in   WIDTH x DEPTH  parallel load data (unpacked array [0:DEPTH-1])
//  wr_addr     in   AW             addressed-write index
//  wr_data     in   WIDTH          addressed-write data and shift-in data
//  wr_err      out  1              1-cycle pulse: addressed write with wr_addr>=DEPTH
//  clear       in   1              request clear sweep (sampled in IDLE only)
//  rd_addr     in   AW             random-read index
//  rd_data     out  WIDTH          registered read data, 1-cycle latency
//  data_out    out  WIDTH x DEPTH  current contents, combinational from storage
//  shift_out   out  WIDTH          registered entry[DEPTH-1] displaced by the last shift
//  fill_count  out  AW+1           valid-entry count, saturates at DEPTH
//  full        out  1              fill_count==DEPTH
//  busy        out  1              state==CLR
// BEHAVIOUR
//  Reset (async, rst=1): all entries, rd_data, shift_out, fill_count=0; wr_err=0; state=IDLE.
//  Accept: an operation fires on a clk edge when load_valid && load_ready; mode 00 fires but changes nothing.
//  Parallel load (01): entry[i]<=data_in[i] for all i; fill_count<=DEPTH.
//  Addressed write (10): entry[wr_addr]<=wr_data; fill_count unchanged.
//   - If wr_addr>=DEPTH: no write, wr_err=1 for one cycle.
//  Shift-in (11): entry[0]<=wr_data; entry[i]<=entry[i-1]; shift_out<=old entry[DEPTH-1].
//   - fill_count<=min(fill_count+1, DEPTH).
//  rd_data<=entry[rd_addr] every cycle; reads the pre-edge contents (no write-through).
//   - rd_addr>=DEPTH returns 0.
//  FSM IDLE/CLR:
//   - IDLE & clear: ->CLR, sweep idx<=0, fill_count<=0; a load_valid in that cycle is not accepted.
//   - CLR: entry[idx]<=0, idx++; load_ready=0, busy=1.
//   - CLR & idx==DEPTH-1: ->IDLE. Sweep takes exactly DEPTH cycles.
//   - clear while in CLR: ignored, no restart.
//  rd_data during CLR reflects partially cleared contents.
//  rst asserted mid-sweep: immediate IDLE, all zero.
//  Hold behaviour: entries not targeted keep their value; no X on any output after reset.
// CONFIGURATION
//  REG_ARRAY_PARITY_EN defined:
//   - Each entry stores an extra even-parity bit, computed on every write; clear and reset store parity of 0.
//   - Adds in par_inject (1): flips the stored parity bit of any entry written that cycle.
//   - Adds out rd_perr (1): registered with rd_data, 1 when the read entry's parity mismatches.
//  REG_ARRAY_PARITY_EN undefined: no parity storage, no par_inject/rd_perr ports.
//  All other behaviour is identical in both builds.
// TESTING
//  Reset then parallel load data_in[i]=i*0x11111111 (DEPTH=16):
//   - data_out matches next cycle; fill_count=16, full=1.
//  Shift 0xA,0xB,0xC after reset:
//   - entry[0]=0xC, entry[1]=0xB, entry[2]=0xA; fill_count=3.
//   - After a full 16-entry bank plus one shift, shift_out = old entry[15].
//  Addressed write addr 5 = 0xDEADBEEF, rd_addr=5 next cycle -> rd_data=0xDEADBEEF one cycle later.
//   - With DEPTH=12, addr 13 -> wr_err pulse, no change.
//  clear and load_valid together in IDLE -> load not accepted.
//   - busy=1 and load_ready=0 for exactly 16 cycles; all entries 0 after; fill_count=0.
//  rst pulsed at sweep cycle 7 -> all outputs 0 and IDLE immediately; next load accepted the following cycle.
//  With REG_ARRAY_PARITY_EN: write addr 3 with par_inject=1, read addr 3 -> rd_perr=1.
//   - Rewrite addr 3 without inject -> rd_perr=0.

Source files
------------

// File: rtl/reg_array_bank.sv
// DEPTH x WIDTH register bank with parallel load, addressed write, shift-in, registered read and clear sweep.
// Optional per-entry even parity when REG_ARRAY_PARITY_EN is defined.
module reg_array_bank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in [0:DEPTH-1],
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             clear,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] data_out [0:DEPTH-1],
  output logic [WIDTH-1:0] shift_out,
  output logic [AW:0]      fill_count,
  output logic             full,
`ifdef REG_ARRAY_PARITY_EN
  input  logic             par_inject,
  output logic             rd_perr,
`endif
  output logic             busy
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLR} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];
  logic [AW-1:0]     idx;
  logic              start_clr;
  logic              accept;
  logic              wr_ok;
  logic              rd_ok;
`ifdef REG_ARRAY_PARITY_EN
  logic              par [0:DEPTH-1];
`endif

  assign start_clr  = (state == IDLE) && clear;
  assign load_ready = (state == IDLE) && !clear;
  assign accept     = load_valid && load_ready;
  assign busy       = (state == CLR);
  assign full       = (fill_count == DEPTH_C);
  assign wr_ok      = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_ok      = ({1'b0, rd_addr} < DEPTH_C);
  assign data_out   = mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear) state_next = CLR;
      CLR:     if (idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data    <= '0;
      shift_out  <= '0;
      fill_count <= '0;
      wr_err     <= 1'b0;
      idx        <= '0;
    end else begin
      wr_err  <= 1'b0;
      // Read samples pre-edge contents, so a same-cycle write is not visible.
      rd_data <= rd_ok ? mem[rd_addr] : '0;
      if (start_clr) begin
        idx        <= '0;
        fill_count <= '0;
      end else if (state == CLR) begin
        mem[idx] <= '0;
        idx      <= idx + 1'b1;
      end else if (accept) begin
        case (mode)
          2'b01: begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= data_in[i];
            fill_count <= DEPTH_C;
          end
          2'b10: begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            else       wr_err <= 1'b1;
          end
          2'b11: begin
            mem[0] <= wr_data;
            for (int unsigned i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            shift_out <= mem[DEPTH-1];
            if (fill_count != DEPTH_C) fill_count <= fill_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef REG_ARRAY_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) par[i] <= 1'b0;
      rd_perr <= 1'b0;
    end else begin
      rd_perr <= rd_ok ? ((^mem[rd_addr]) != par[rd_addr]) : 1'b0;
      if (state == CLR) begin
        par[idx] <= 1'b0;
      end else if (accept) begin
        case (mode)
          2'b01: for (int unsigned i = 0; i < DEPTH; i++) par[i] <= (^data_in[i]) ^ par_inject;
          2'b10: if (wr_ok) par[wr_addr] <= (^wr_data) ^ par_inject;
          2'b11: begin
            par[0] <= (^wr_data) ^ par_inject;
            for (int unsigned i = 1; i < DEPTH; i++) par[i] <= par[i-1] ^ par_inject;
          end
          default: ;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_array_bank.sv
// Directed bench for reg_array_bank; read results tracked through an expected-value queue.
module tb_reg_array_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] data_in [0:15];
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_err;
  logic        clear;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] data_out [0:15];
  logic [31:0] shift_out;
  logic [4:0]  fill_count;
  logic        full;
  logic        busy;

  logic [1:0]  mode12;
  logic        load_valid12;
  logic        load_ready12;
  logic [31:0] data_in12 [0:11];
  logic [3:0]  wr_addr12;
  logic [31:0] wr_data12;
  logic        wr_err12;
  logic        clear12;
  logic [3:0]  rd_addr12;
  logic [31:0] rd_data12;
  logic [31:0] data_out12 [0:11];
  logic [31:0] shift_out12;
  logic [4:0]  fill_count12;
  logic        full12;
  logic        busy12;
`ifdef REG_ARRAY_PARITY_EN
  logic        par_inject, rd_perr, par_inject12, rd_perr12;
`endif

  reg_array_bank #(.WIDTH(32), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .clear(clear),
    .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out), .shift_out(shift_out),
    .fill_count(fill_count), .full(full),
`ifdef REG_ARRAY_PARITY_EN
    .par_inject(par_inject), .rd_perr(rd_perr),
`endif
    .busy(busy));

  reg_array_bank #(.WIDTH(32), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .mode(mode12), .load_valid(load_valid12), .load_ready(load_ready12),
    .data_in(data_in12), .wr_addr(wr_addr12), .wr_data(wr_data12), .wr_err(wr_err12), .clear(clear12),
    .rd_addr(rd_addr12), .rd_data(rd_data12), .data_out(data_out12), .shift_out(shift_out12),
    .fill_count(fill_count12), .full(full12),
`ifdef REG_ARRAY_PARITY_EN
    .par_inject(par_inject12), .rd_perr(rd_perr12),
`endif
    .busy(busy12));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [0:15];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s[%0d]", tag, i), 64'(data_out[i]), 64'(model[i]));
  endtask

  task automatic model_shift(input logic [31:0] d);
    for (int i = 15; i > 0; i--) model[i] = model[i-1];
    model[0] = d;
  endtask

  task automatic read_step(input logic [3:0] a);
    rd_addr = a;
    exp_q.push_back(model[a]);
    tick();
    check($sformatf("rd_data@%0d", a), 64'(rd_data), 64'(exp_q.pop_front()));
  endtask

  task automatic shift_in(input logic [31:0] d);
    mode = 2'b11; wr_data = d; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    model_shift(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] old15;
    rst = 1'b1; mode = 2'b00; load_valid = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0; rd_addr = '0;
    mode12 = 2'b00; load_valid12 = 1'b0; wr_addr12 = '0; wr_data12 = '0; clear12 = 1'b0; rd_addr12 = '0;
    for (int i = 0; i < 16; i++) data_in[i] = '0;
    for (int i = 0; i < 12; i++) data_in12[i] = '0;
`ifdef REG_ARRAY_PARITY_EN
    par_inject = 1'b0; par_inject12 = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    check_bank("reset_entry");
    check("reset_fill", 64'(fill_count), 64'd0);
    check("reset_full", 64'(full), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(load_ready), 64'd1);
    check("reset_rd", 64'(rd_data), 64'd0);
    check("reset_shift_out", 64'(shift_out), 64'd0);
    check("reset_wr_err", 64'(wr_err), 64'd0);

    // Parallel load
    for (int i = 0; i < 16; i++) begin
      data_in[i] = 32'(i) * 32'h11111111;
      model[i] = data_in[i];
    end
    mode = 2'b01; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check_bank("pload");
    check("pload_fill", 64'(fill_count), 64'd16);
    check("pload_full", 64'(full), 64'd1);

    // Shift into a full bank
    old15 = model[15];
    shift_in(32'h5);
    check("shift_full_out", 64'(shift_out), 64'(old15));
    check("shift_full_fill", 64'(fill_count), 64'd16);
    check_bank("shift_full");

    // Shift sequence after reset
    do_reset();
    shift_in(32'hA); shift_in(32'hB); shift_in(32'hC);
    check("shift3_e0", 64'(data_out[0]), 64'hC);
    check("shift3_e1", 64'(data_out[1]), 64'hB);
    check("shift3_e2", 64'(data_out[2]), 64'hA);
    check("shift3_fill", 64'(fill_count), 64'd3);
    check("shift3_out", 64'(shift_out), 64'd0);

    // Addressed write then registered read
    mode = 2'b10; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    model[5] = 32'hDEADBEEF;
    check("awr_wr_err", 64'(wr_err), 64'd0);
    check("awr_fill", 64'(fill_count), 64'd3);
    read_step(4'd5);
    read_step(4'd0);
    read_step(4'd2);
    read_step(4'd15);

    // Same-cycle write and read returns the old value
    mode = 2'b10; wr_addr = 4'd2; wr_data = 32'h12345678; load_valid = 1'b1;
    rd_addr = 4'd2;
    exp_q.push_back(model[2]);
    model[2] = 32'h12345678;
    tick();
    load_valid = 1'b0;
    check("rd_no_writethrough", 64'(rd_data), 64'(exp_q.pop_front()));
    read_step(4'd2);

    // Mode 00 fires but changes nothing
    mode = 2'b00; load_valid = 1'b1; wr_data = 32'hFFFFFFFF;
    tick();
    load_valid = 1'b0;
    check_bank("hold");
    check("hold_fill", 64'(fill_count), 64'd3);

    // DEPTH=12 out-of-range write
    mode12 = 2'b10; wr_addr12 = 4'd13; wr_data12 = 32'hCAFEF00D; load_valid12 = 1'b1;
    rd_addr12 = 4'd13;
    tick();
    load_valid12 = 1'b0;
    check("d12_wr_err_pulse", 64'(wr_err12), 64'd1);
    check("d12_rd_oob", 64'(rd_data12), 64'd0);
    for (int i = 0; i < 12; i++) check($sformatf("d12_entry[%0d]", i), 64'(data_out12[i]), 64'd0);
    tick();
    check("d12_wr_err_clear", 64'(wr_err12), 64'd0);
    mode12 = 2'b10; wr_addr12 = 4'd11; load_valid12 = 1'b1;
    tick();
    load_valid12 = 1'b0;
    check("d12_last_write", 64'(data_out12[11]), 64'hCAFEF00D);
    check("d12_last_wr_err", 64'(wr_err12), 64'd0);

    // Clear with simultaneous load request
    for (int i = 0; i < 16; i++) data_in[i] = 32'hFFFFFFFF;
    mode = 2'b01; load_valid = 1'b1; clear = 1'b1;
    #1;
    check("clear_ready_low", 64'(load_ready), 64'd0);
    tick();
    load_valid = 1'b0; clear = 1'b0;
    check("clr_fill0", 64'(fill_count), 64'd0);
    check("clr_e5_pending", 64'(data_out[5]), 64'hDEADBEEF);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check("clr_ready", 64'(load_ready), 64'd0);
      clear = (n == 3);
      n++;
      tick();
    end
    clear = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check("clr_cycles", 64'(n), 64'd16);
    check_bank("clr_done");
    check("clr_done_fill", 64'(fill_count), 64'd0);
    check("clr_done_ready", 64'(load_ready), 64'd1);

    // Reset mid-sweep
    for (int i = 0; i < 16; i++) data_in[i] = 32'h0F0F0000 + 32'(i);
    mode = 2'b01; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_partial_e6", 64'(data_out[6]), 64'd0);
    check("mid_partial_e7", 64'(data_out[7]), 64'h0F0F0007);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_bank("mid_rst");
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(load_ready), 64'd1);
    check("mid_rst_fill", 64'(fill_count), 64'd0);
    check("mid_rst_rd", 64'(rd_data), 64'd0);
    check("mid_rst_shift_out", 64'(shift_out), 64'd0);
    #2;
    rst = 1'b0;
    mode = 2'b01; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0F0F0000 + 32'(i);
    check_bank("post_rst_load");
    check("post_rst_full", 64'(full), 64'd1);

`ifdef REG_ARRAY_PARITY_EN
    mode = 2'b10; wr_addr = 4'd3; wr_data = 32'h00000007; par_inject = 1'b1; load_valid = 1'b1;
    tick();
    load_valid = 1'b0; par_inject = 1'b0;
    model[3] = 32'h7;
    rd_addr = 4'd3;
    tick();
    check("perr_inject", 64'(rd_perr), 64'd1);
    check("perr_inject_rd", 64'(rd_data), 64'h7);
    mode = 2'b10; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    check("perr_clean", 64'(rd_perr), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
